// File: rtl/correlator_peak_detector.sv
// correlator_peak_detector
// Watches an unsigned correlation stream, opens an event when a sample reaches
// Threshold, tracks the running maximum and its sample index, closes the event
// after PEAK_WINDOW consecutive non-improving samples and then ignores
// HOLDOFF_LENGTH valid samples so sidelobes cannot re-trigger it. One
// registered report (value, index) is produced per closed event.
module correlator_peak_detector #(
  parameter int DATA_WIDTH     = 16,
  parameter int INDEX_WIDTH    = 32,
  parameter int PEAK_WINDOW    = 16,
  parameter int HOLDOFF_LENGTH = 64
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Input_valid,
  input  logic [DATA_WIDTH-1:0]  Input_data,
  input  logic [DATA_WIDTH-1:0]  Threshold,
  output logic                   Output_valid,
  output logic [DATA_WIDTH-1:0]  Output_peak_value,
  output logic [INDEX_WIDTH-1:0] Output_peak_index
);

  // A zero-length holdoff still needs a one-bit counter so the vector is legal.
  localparam int WIN_W  = $clog2(PEAK_WINDOW + 1);
  localparam int HOLD_W = (HOLDOFF_LENGTH > 0) ? $clog2(HOLDOFF_LENGTH + 1) : 1;

  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(PEAK_WINDOW);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_LENGTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRACK,
    S_HOLDOFF
  } state_e;

  state_e                 state_q,     state_d;
  logic [INDEX_WIDTH-1:0] idx_q,       idx_d;
  logic [DATA_WIDTH-1:0]  max_q,       max_d;
  logic [INDEX_WIDTH-1:0] max_idx_q,   max_idx_d;
  logic [WIN_W-1:0]       win_cnt_q,   win_cnt_d;
  logic [HOLD_W-1:0]      hold_cnt_q,  hold_cnt_d;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]  out_value_q, out_value_d;
  logic [INDEX_WIDTH-1:0] out_index_q, out_index_d;

  // Next-state logic: nothing moves unless a valid sample is presented.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    max_d       = max_q;
    max_idx_d   = max_idx_q;
    win_cnt_d   = win_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    out_valid_d = 1'b0;
    out_value_d = out_value_q;
    out_index_d = out_index_q;

    if (Input_valid) begin
      // The sample index advances on every valid sample regardless of state.
      idx_d = idx_q + INDEX_WIDTH'(1);

      case (state_q)
        S_IDLE: begin
          if (Input_data >= Threshold) begin
            max_d     = Input_data;
            max_idx_d = idx_q;
            win_cnt_d = '0;
            state_d   = S_TRACK;
          end
        end

        S_TRACK: begin
          // Strict compare: on a tie the earlier index is kept.
          if (Input_data > max_q) begin
            max_d     = Input_data;
            max_idx_d = idx_q;
            win_cnt_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
            if (win_cnt_d == WIN_LAST) begin
              out_valid_d = 1'b1;
              out_value_d = max_q;
              out_index_d = max_idx_q;
              win_cnt_d   = '0;
              hold_cnt_d  = '0;
              state_d     = (HOLDOFF_LENGTH == 0) ? S_IDLE : S_HOLDOFF;
            end
          end
        end

        S_HOLDOFF: begin
          // The sample that completes the holdoff is discarded, not tested.
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          if (hold_cnt_d == HOLD_LAST) begin
            state_d = S_IDLE;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and report registers; reset drops any open event without a report.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      max_q       <= '0;
      max_idx_q   <= '0;
      win_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_index_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      idx_q       <= idx_d;
      max_q       <= max_d;
      max_idx_q   <= max_idx_d;
      win_cnt_q   <= win_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      out_valid_q <= out_valid_d;
      out_value_q <= out_value_d;
      out_index_q <= out_index_d;
    end
  end

  assign Output_valid      = out_valid_q;
  assign Output_peak_value = out_value_q;
  assign Output_peak_index = out_index_q;

endmodule
